// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operation sequencer: opcodes, FSM state
// encoding, header field positions, operand width derivation.
// Purely declarative: no logic, no latency, no flow control.
package matrix_pkg;

    localparam int ELEM_W_DEF = 8;
    localparam int MAX_N_DEF  = 5;
    localparam int ADDR_W_DEF = 8;

    // A full operand is a MAX_N x MAX_N matrix, row-major, [0][0] in the MSBs.
    function automatic int mat_width(input int elem_w, input int max_n);
        return elem_w * max_n * max_n;
    endfunction

    localparam int MAT_W_DEF = mat_width(ELEM_W_DEF, MAX_N_DEF);

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_ADD     = 3'd0;
    localparam opcode_t OP_SUB     = 3'd1;
    localparam opcode_t OP_MMUL    = 3'd2;
    localparam opcode_t OP_SMUL    = 3'd3;
    localparam opcode_t OP_DET     = 3'd4;
    localparam opcode_t OP_TRANSP  = 3'd5;
    localparam opcode_t OP_NEG     = 3'd6;
    localparam opcode_t OP_ILLEGAL = 3'd7;

    // Header word layout (low bits of the memory word at base+0).
    localparam int HDR_SIZE_LSB = 0;
    localparam int HDR_SIZE_W   = 8;
    localparam int HDR_OP_LSB   = 8;
    localparam int HDR_OP_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_HDR = 3'd1,
        ST_FETCH_A   = 3'd2,
        ST_FETCH_B   = 3'd3,
        ST_EXEC      = 3'd4,
        ST_WRITE     = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    function automatic logic is_unary(input opcode_t op);
        return (op == OP_DET) || (op == OP_TRANSP) || (op == OP_NEG);
    endfunction

endpackage

// File: rtl/matrix_op_sequencer_if.sv
// Memory and ALU bundle between the sequencer (master) and memory/ALU (slave).
// Ports: mem_addr/mem_wren/mem_wdata/mem_rdata, alu_req/op/size/a/b, alu_result/ovf/ack.
// Latency/backpressure are defined by the endpoints; alu_req is held until alu_ack.
interface matrix_op_sequencer_if #(
    parameter int ADDR_W = matrix_pkg::ADDR_W_DEF,
    parameter int MAT_W  = matrix_pkg::MAT_W_DEF
);
    import matrix_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [MAT_W-1:0]  mem_wdata;
    logic [MAT_W-1:0]  mem_rdata;

    logic              alu_req;
    opcode_t           alu_op;
    logic [2:0]        alu_size;
    logic [MAT_W-1:0]  alu_a;
    logic [MAT_W-1:0]  alu_b;
    logic [MAT_W-1:0]  alu_result;
    logic              alu_ovf;
    logic              alu_ack;

    modport master (
        output mem_addr, mem_wren, mem_wdata,
        input  mem_rdata,
        output alu_req, alu_op, alu_size, alu_a, alu_b,
        input  alu_result, alu_ovf, alu_ack
    );

    modport slave (
        input  mem_addr, mem_wren, mem_wdata,
        output mem_rdata,
        input  alu_req, alu_op, alu_size, alu_a, alu_b,
        output alu_result, alu_ovf, alu_ack
    );

endinterface

// File: rtl/op_watchdog.sv
// ALU watchdog: flags expiry on the LIMIT-th consecutive enabled cycle.
// Ports: clk, rst (sync, active-high), en_i (sequencer in EXEC), expired_o.
// Zero-latency flag (combinational from count); counter clears whenever en_i drops.
// Only built when MATRIX_OP_SEQUENCER_TIMEOUT_EN is defined.
`ifdef MATRIX_OP_SEQUENCER_TIMEOUT_EN
module op_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The sequencer leaves EXEC on expiry, so the count never needs to saturate.
    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/matrix_op_sequencer.sv
// Matrix coprocessor sequencer: fetch header/A/B, dispatch to ALU, write result, report.
// Ports: clk, rst, start, base_addr, busy/done/overflow/err, state_o, opcode_o, bus (master).
// Latency (READ_LAT=1, ack in first EXEC cycle): binary 9, unary 7, illegal header 3 cycles
// from start edge to done; EXEC stalls until alu_ack. Build option:
// MATRIX_OP_SEQUENCER_TIMEOUT_EN adds a watchdog that aborts EXEC after TIMEOUT_CYC cycles.
module matrix_op_sequencer
    import matrix_pkg::*;
#(
    parameter int ELEM_W      = 8,
    parameter int MAX_N       = 5,
    parameter int ADDR_W      = 8,
    parameter int READ_LAT    = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  err,
    output logic [2:0]            state_o,
    output logic [2:0]            opcode_o,
    matrix_op_sequencer_if.master bus
);
    localparam int MAT_W = mat_width(ELEM_W, MAX_N);
    localparam int CNT_W = $clog2(READ_LAT + 1);

    if (READ_LAT < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("matrix_op_sequencer: READ_LAT and TIMEOUT_CYC must be >= 1");
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    opcode_t             opcode_q, opcode_d;
    logic [2:0]          size_q, size_d;
    logic [MAT_W-1:0]    a_q, a_d;
    logic [MAT_W-1:0]    b_q, b_d;
    logic [MAT_W-1:0]    res_q, res_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;

    // Header decode straight off the read bus; only consumed in FETCH_HDR.
    logic [HDR_SIZE_W-1:0] hdr_size_code;
    opcode_t               hdr_op;
    logic                  hdr_illegal;
    logic                  fetch_hit;

    assign hdr_size_code = bus.mem_rdata[HDR_SIZE_LSB +: HDR_SIZE_W];
    assign hdr_op        = bus.mem_rdata[HDR_OP_LSB +: HDR_OP_W];
    assign hdr_illegal   = (hdr_op == OP_ILLEGAL) ||
                           (hdr_size_code > HDR_SIZE_W'(MAX_N - 2));
    assign fetch_hit     = (cnt_q == CNT_W'(READ_LAT));

`ifdef MATRIX_OP_SEQUENCER_TIMEOUT_EN
    logic wd_expired;

    op_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_op_watchdog (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == ST_EXEC),
        .expired_o (wd_expired)
    );
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        opcode_d = opcode_q;
        size_d   = size_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_FETCH_HDR;
                end
            end
            ST_FETCH_HDR: begin
                if (fetch_hit) begin
                    cnt_d    = '0;
                    opcode_d = hdr_op;
                    size_d   = 3'(hdr_size_code) + 3'd2;
                    if (hdr_illegal) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH_A;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FETCH_A: begin
                if (fetch_hit) begin
                    cnt_d = '0;
                    a_d   = bus.mem_rdata;
                    if (is_unary(opcode_q)) begin
                        b_d     = '0;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_FETCH_B;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FETCH_B: begin
                if (fetch_hit) begin
                    cnt_d   = '0;
                    b_d     = bus.mem_rdata;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EXEC: begin
                // A same-cycle ack wins over watchdog expiry.
                if (bus.alu_ack) begin
                    res_d   = bus.alu_result;
                    ovf_d   = bus.alu_ovf;
                    state_d = ST_WRITE;
                end
`ifdef MATRIX_OP_SEQUENCER_TIMEOUT_EN
                else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_WRITE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            opcode_q <= '0;
            size_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            opcode_q <= opcode_d;
            size_q   <= size_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // Address is held for the whole fetch so the synchronous memory sees it
    // from the first fetch cycle. EXEC/DONE park on base+3 so base+2 is only
    // ever presented while fetching B.
    always_comb begin
        bus.mem_addr = base_q + ADDR_W'(3);
        unique case (state_q)
            ST_IDLE:      bus.mem_addr = base_addr;
            ST_FETCH_HDR: bus.mem_addr = base_q;
            ST_FETCH_A:   bus.mem_addr = base_q + ADDR_W'(1);
            ST_FETCH_B:   bus.mem_addr = base_q + ADDR_W'(2);
            default:      bus.mem_addr = base_q + ADDR_W'(3);
        endcase
    end

    assign bus.mem_wren  = (state_q == ST_WRITE);
    assign bus.mem_wdata = res_q;
    assign bus.alu_req   = (state_q == ST_EXEC);
    assign bus.alu_op    = opcode_q;
    assign bus.alu_size  = size_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign overflow = ovf_q;
    assign err      = err_q;
    assign state_o  = state_q;
    assign opcode_o = opcode_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
module tb_matrix_op_sequencer;
    import matrix_pkg::*;

    localparam int ELEM_W      = 8;
    localparam int MAX_N       = 5;
    localparam int ADDR_W      = 8;
    localparam int READ_LAT    = 1;
    localparam int TIMEOUT_CYC = 64;
    localparam int MAT_W       = ELEM_W * MAX_N * MAX_N;

    typedef logic [MAT_W-1:0] mat_t;

    typedef struct {
        string      name;
        logic [7:0] base;
        opcode_t    op;
        logic [7:0] sc;
        mat_t       a;
        mat_t       b;
        int         ack;
        bit         pulse;
        mat_t       exp_res;
        bit         exp_ovf;
        bit         exp_err;
        int         exp_done;
        bit         exp_req;
        bit         exp_saw_b;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy, done, overflow, err;
    logic [2:0]        state_o, opcode_o;

    matrix_op_sequencer_if #(.ADDR_W(ADDR_W), .MAT_W(MAT_W)) bus ();

    matrix_op_sequencer #(
        .ELEM_W(ELEM_W), .MAX_N(MAX_N), .ADDR_W(ADDR_W),
        .READ_LAT(READ_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .overflow(overflow), .err(err),
        .state_o(state_o), .opcode_o(opcode_o), .bus(bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory, one cycle latency.
    mat_t mem [256];
    mat_t rdata_q = '0;
    always @(posedge clk) rdata_q <= mem[bus.mem_addr];
    assign bus.mem_rdata = rdata_q;

    // ALU stub: ack on the ack_cyc-th cycle of a request.
    int   ack_cyc = 1;
    int   req_cnt = 0;
    mat_t stub_res;
    logic stub_ovf;

    always @(posedge clk) begin
        if (bus.alu_req && !bus.alu_ack) req_cnt <= req_cnt + 1;
        else                             req_cnt <= 0;
    end
    assign bus.alu_ack = bus.alu_req && (req_cnt == ack_cyc - 1);

    always_comb begin
        logic [8:0] s;
        logic [7:0] ea, eb;
        stub_res = '0;
        stub_ovf = 1'b0;
        for (int r = 0; r < MAX_N; r++) begin
            for (int c = 0; c < MAX_N; c++) begin
                ea = bus.alu_a[MAT_W-1-(r*MAX_N+c)*ELEM_W -: ELEM_W];
                eb = bus.alu_b[MAT_W-1-(r*MAX_N+c)*ELEM_W -: ELEM_W];
                s  = '0;
                case (bus.alu_op)
                    OP_ADD:    s = {ea[7], ea} + {eb[7], eb};
                    OP_SUB:    s = {ea[7], ea} - {eb[7], eb};
                    OP_TRANSP: s = {1'b0, bus.alu_a[MAT_W-1-(c*MAX_N+r)*ELEM_W -: ELEM_W]};
                    default:   s = 9'd0 - {ea[7], ea};
                endcase
                if ((bus.alu_op == OP_ADD || bus.alu_op == OP_SUB) && (s[8] != s[7]))
                    stub_ovf = 1'b1;
                stub_res[MAT_W-1-(r*MAX_N+c)*ELEM_W -: ELEM_W] = s[7:0];
            end
        end
    end
    assign bus.alu_result = stub_res;
    assign bus.alu_ovf    = stub_ovf;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chkm(input string name, input mat_t act, input mat_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // 3x3 top-left block, remaining elements zero.
    function automatic mat_t m9(int e0, int e1, int e2, int e3, int e4,
                                int e5, int e6, int e7, int e8);
        mat_t v = '0;
        int   e[9] = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
        for (int i = 0; i < 9; i++)
            v[MAT_W-1-((i/3)*MAX_N + i%3)*ELEM_W -: ELEM_W] = 8'(e[i]);
        return v;
    endfunction

    function automatic mat_t hdr(opcode_t op, logic [7:0] sc);
        mat_t h = '0;
        h[10:8] = op;
        h[7:0]  = sc;
        return h;
    endfunction

    function automatic vec_t mk(string name, logic [7:0] base, opcode_t op, logic [7:0] sc,
                                mat_t a, mat_t b, int ack, bit pulse, mat_t exp_res,
                                bit exp_ovf, bit exp_err, int exp_done, bit exp_saw_b);
        vec_t v;
        v.name = name; v.base = base; v.op = op; v.sc = sc; v.a = a; v.b = b;
        v.ack = ack; v.pulse = pulse; v.exp_res = exp_res; v.exp_ovf = exp_ovf;
        v.exp_err = exp_err; v.exp_done = exp_done; v.exp_req = !exp_err;
        v.exp_saw_b = exp_saw_b;
        return v;
    endfunction

    task automatic run(input vec_t v);
        int         cyc, done_cyc, wcnt;
        logic [7:0] waddr, a2, a3;
        mat_t       wdata, ra, rb;
        logic [2:0] rop, rsz;
        bit         req_seen, unstable, saw_b;
        logic       ovf1, err1;
        a2 = v.base + 8'd2;
        a3 = v.base + 8'd3;
        mem[v.base]            = hdr(v.op, v.sc);
        mem[8'(v.base + 8'd1)] = v.a;
        mem[a2]                = v.b;
        mem[a3]                = {(MAT_W/8){8'hA5}};
        ack_cyc = v.ack;
        wcnt = 0; waddr = '0; wdata = '0; ra = '0; rb = '0; rop = '0; rsz = '0;
        req_seen = 0; unstable = 0; saw_b = 0; ovf1 = 1'b1; err1 = 1'b1;
        @(posedge clk); #1;
        base_addr = v.base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        done_cyc = -1;
        while (cyc <= 200) begin
            if (cyc == 1) begin ovf1 = overflow; err1 = err; end
            if (bus.mem_wren) begin wcnt++; waddr = bus.mem_addr; wdata = bus.mem_wdata; end
            if (bus.mem_addr == a2) saw_b = 1;
            if (bus.alu_req) begin
                if (!req_seen) begin
                    req_seen = 1; ra = bus.alu_a; rb = bus.alu_b;
                    rop = bus.alu_op; rsz = bus.alu_size;
                end else if (ra !== bus.alu_a || rb !== bus.alu_b ||
                             rop !== bus.alu_op || rsz !== bus.alu_size) begin
                    unstable = 1;
                end
            end
            if (v.pulse) start = (cyc == 3 || cyc == 7);
            if (done) begin done_cyc = cyc; break; end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({v.name, ".done_cyc"}, done_cyc, v.exp_done);
        chk({v.name, ".ovf_clr_on_start"}, int'(ovf1), 0);
        chk({v.name, ".err_clr_on_start"}, int'(err1), 0);
        chk({v.name, ".overflow"}, int'(overflow), int'(v.exp_ovf));
        chk({v.name, ".err"}, int'(err), int'(v.exp_err));
        chk({v.name, ".opcode_o"}, int'(opcode_o), int'(v.op));
        chk({v.name, ".req_seen"}, int'(req_seen), int'(v.exp_req));
        chk({v.name, ".addr_b_seen"}, int'(saw_b), int'(v.exp_saw_b));
        if (v.exp_err) begin
            chk({v.name, ".wren_cnt"}, wcnt, 0);
        end else begin
            chk({v.name, ".wren_cnt"}, wcnt, 1);
            chk({v.name, ".wr_addr"}, int'(waddr), int'(a3));
            chkm({v.name, ".wr_data"}, wdata, v.exp_res);
        end
        if (v.exp_req) begin
            chk({v.name, ".operands_stable"}, int'(unstable), 0);
            chk({v.name, ".alu_size"}, int'(rsz), int'(3'(v.sc + 8'd2)));
            chkm({v.name, ".alu_a"}, ra, v.a);
            chkm({v.name, ".alu_b"}, rb, is_unary(v.op) ? '0 : v.b);
        end
        @(posedge clk); #1;
        chk({v.name, ".done_one_cycle"}, int'(done), 0);
        chk({v.name, ".idle_after"}, int'(busy), 0);
        @(posedge clk); #1;
        chk({v.name, ".no_restart"}, int'(busy), 0);
    endtask

    vec_t tv[$];

    initial begin
        int   n;
        bit   seen_done;
        vec_t tov;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1; start = 1'b0; base_addr = '0;

        tv.push_back(mk("add2x2", 8'h10, OP_ADD, 8'd0, m9(1,2,0,3,4,0,0,0,0),
                        m9(5,6,0,7,8,0,0,0,0), 1, 0, m9(6,8,0,10,12,0,0,0,0), 0, 0, 9, 1));
        tv.push_back(mk("add_ovf", 8'h20, OP_ADD, 8'd0, m9(127,0,0,0,0,0,0,0,0),
                        m9(1,0,0,0,0,0,0,0,0), 1, 0, m9(-128,0,0,0,0,0,0,0,0), 1, 0, 9, 1));
        tv.push_back(mk("ill_op", 8'h30, OP_ILLEGAL, 8'd0, m9(1,1,0,1,1,0,0,0,0),
                        m9(2,2,0,2,2,0,0,0,0), 1, 0, '0, 0, 1, 3, 0));
        tv.push_back(mk("ill_size", 8'h40, OP_ADD, 8'd4, m9(1,1,0,1,1,0,0,0,0),
                        m9(2,2,0,2,2,0,0,0,0), 1, 0, '0, 0, 1, 3, 0));
        tv.push_back(mk("transp3", 8'h50, OP_TRANSP, 8'd1, m9(1,2,3,4,5,6,7,8,9),
                        m9(9,9,9,9,9,9,9,9,9), 1, 0, m9(1,4,7,2,5,8,3,6,9), 0, 0, 7, 0));
        tv.push_back(mk("det_slow", 8'h60, OP_DET, 8'd1, m9(1,2,3,4,5,6,7,8,9),
                        m9(3,3,3,3,3,3,3,3,3), 5, 1, m9(-1,-2,-3,-4,-5,-6,-7,-8,-9), 0, 0, 11, 0));
        tv.push_back(mk("sub_wrap", 8'hFE, OP_SUB, 8'd0, m9(5,5,0,5,5,0,0,0,0),
                        m9(1,2,0,3,4,0,0,0,0), 1, 0, m9(4,3,0,2,1,0,0,0,0), 0, 0, 9, 1));
        tv.push_back(mk("neg2x2", 8'h70, OP_NEG, 8'd0, m9(3,-4,0,0,0,0,0,0,0),
                        m9(1,1,0,1,1,0,0,0,0), 1, 0, m9(-3,4,0,0,0,0,0,0,0), 0, 0, 7, 0));
        tv.push_back(mk("add5x5", 8'h80, OP_ADD, 8'd3, m9(1,1,1,1,1,1,1,1,1),
                        m9(2,2,2,2,2,2,2,2,2), 1, 0, m9(3,3,3,3,3,3,3,3,3), 0, 0, 9, 1));

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.overflow", int'(overflow), 0);
        chk("rst.err", int'(err), 0);
        chk("rst.state_o", int'(state_o), 0);
        chk("rst.opcode_o", int'(opcode_o), 0);
        chk("rst.alu_req", int'(bus.alu_req), 0);
        chk("rst.mem_wren", int'(bus.mem_wren), 0);
        chk("rst.mem_addr", int'(bus.mem_addr), 0);
        chkm("rst.alu_a", bus.alu_a, '0);
        chkm("rst.mem_wdata", bus.mem_wdata, '0);
        rst = 1'b0;

        foreach (tv[i]) run(tv[i]);

        // Overflow stays set while idle, then the next start clears it.
        run(tv[1]);
        repeat (3) @(posedge clk);
        #1;
        chk("sticky.overflow", int'(overflow), 1);
        run(tv[0]);

        // Reset in EXEC with an ALU that never answers.
        ack_cyc = 100000;
        mem[8'h90] = hdr(OP_ADD, 8'd0);
        @(posedge clk); #1;
        base_addr = 8'h90; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (state_o != 3'd4 && n < 20) begin @(posedge clk); #1; n++; end
        chk("rstx.reached_exec", int'(state_o), 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstx.busy", int'(busy), 0);
        chk("rstx.alu_req", int'(bus.alu_req), 0);
        chk("rstx.mem_wren", int'(bus.mem_wren), 0);
        chk("rstx.done", int'(done), 0);
        seen_done = 0;
        repeat (5) begin @(posedge clk); #1; if (done || busy) seen_done = 1; end
        chk("rstx.quiet_after", int'(seen_done), 0);

`ifdef MATRIX_OP_SEQUENCER_TIMEOUT_EN
        // Watchdog: 64 EXEC cycles (7..70), done at 71, no write.
        tov = mk("timeout", 8'hA0, OP_ADD, 8'd0, m9(1,0,0,0,0,0,0,0,0),
                 m9(1,0,0,0,0,0,0,0,0), 100000, 0, '0, 0, 1, 71, 1);
        tov.exp_req = 1;
        run(tov);
        chk("timeout.alu_req_dropped", int'(bus.alu_req), 0);
`else
        tov = tv[0];
        run(tov);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
